// File: rtl/dynamic_display_scanner_pkg.sv
// Shared types and constants for the 4-digit 7-segment display scanner.
// Provides the data path typedefs, the default slot/blanking counts, the
// digit byte positions inside the 32-bit input word, the slot phase enum
// and two small decode helpers.
package dynamic_display_scanner_pkg;

  localparam int DD_IN_WIDTH   = 32;
  localparam int DD_OUT_WIDTH  = 8;
  localparam int DD_GATE_WIDTH = 4;
  localparam int COUNT_WIDTH   = 28;
  localparam int DD_DIGIT_NUM  = 4;

  typedef logic [DD_IN_WIDTH-1:0]   DD_InPath;
  typedef logic [DD_OUT_WIDTH-1:0]  DD_OutPath;
  typedef logic [DD_GATE_WIDTH-1:0] DD_GatePath;
  typedef logic [COUNT_WIDTH-1:0]   CountPath;
  typedef logic [1:0]               DigitIdx;

  localparam CountPath DEF_COUNT      = 28'h3000;
  localparam CountPath DD_BLANK_COUNT = 28'd16;

  localparam int LED_0_POS = 24;
  localparam int LED_1_POS = 16;
  localparam int LED_2_POS = 8;
  localparam int LED_3_POS = 0;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } slot_phase_t;

  // Segment byte belonging to digit idx (digit0 sits in the top byte).
  function automatic DD_OutPath digit_byte(input DD_InPath frame, input DigitIdx idx);
    case (idx)
      2'd0:    return frame[LED_0_POS +: DD_OUT_WIDTH];
      2'd1:    return frame[LED_1_POS +: DD_OUT_WIDTH];
      2'd2:    return frame[LED_2_POS +: DD_OUT_WIDTH];
      default: return frame[LED_3_POS +: DD_OUT_WIDTH];
    endcase
  endfunction

  // Active-high one-hot gate for digit idx.
  function automatic DD_GatePath digit_gate(input DigitIdx idx);
    return DD_GatePath'(1) << idx;
  endfunction

endpackage

// File: rtl/dynamic_display_scanner_if.sv
// Bus between the IO register block and the display scanner.
//   enable     : scan enable (upstream -> scanner)
//   ddIn       : four raw segment bytes (upstream -> scanner)
//   segOut     : segment drive for the gated digit (scanner -> pins)
//   gateOut    : one-hot digit gate (scanner -> pins)
//   frameStart : one-cycle pulse after ddIn was captured (scanner -> upstream)
// master = upstream/pin side, slave = the scanner.
interface dynamic_display_scanner_if;
  import dynamic_display_scanner_pkg::*;

  logic       enable;
  DD_InPath   ddIn;
  DD_OutPath  segOut;
  DD_GatePath gateOut;
  logic       frameStart;

  modport master (
    output enable, ddIn,
    input  segOut, gateOut, frameStart
  );

  modport slave (
    input  enable, ddIn,
    output segOut, gateOut, frameStart
  );

endinterface

// File: rtl/dynamic_display_scanner_slot_timer.sv
// Slot timer for the display scanner: owns the in-slot counter, the digit
// index and the BLANK/SHOW phase.
//   clk, rst  : clock, asynchronous active-high reset
//   enable    : low forces the scan back to digit 0, slot start
//   idx       : current digit
//   slotShow  : current cycle is in the SHOW phase of the slot
//   captureEn : this cycle is a frame capture cycle
module dd_slot_timer
  import dynamic_display_scanner_pkg::*;
#(
  parameter CountPath DWELL_CYCLES = DEF_COUNT,
  parameter CountPath BLANK_CYCLES = DD_BLANK_COUNT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    enable,
  output DigitIdx idx,
  output logic    slotShow,
  output logic    captureEn
);

  CountPath    cnt;
  slot_phase_t phase;

  // Phase is tracked as a register alongside cnt; BLANK_CYCLES >= 1 means
  // cnt == 0 is always BLANK, so re-entering BLANK at slot end is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      phase <= PH_BLANK;
    end else if (!enable) begin
      cnt   <= '0;
      idx   <= '0;
      phase <= PH_BLANK;
    end else if (cnt == DWELL_CYCLES - CountPath'(1)) begin
      cnt   <= '0;
      idx   <= idx + 2'd1;
      phase <= PH_BLANK;
    end else begin
      cnt <= cnt + CountPath'(1);
      if (cnt + CountPath'(1) == BLANK_CYCLES) begin
        phase <= PH_SHOW;
      end
    end
  end

  assign slotShow  = (phase == PH_SHOW);
  assign captureEn = enable && (idx == '0) && (cnt == '0);

endmodule

// File: rtl/dynamic_display_scanner.sv
// Time-multiplexing driver for a 4-digit 7-segment display. Latches the
// 32-bit segment word once per frame and scans the digits one slot at a
// time, with a blanking gap at the start of every slot.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of dynamic_display_scanner_if (enable, ddIn in;
//              segOut, gateOut, frameStart out, all registered)
// ACTIVE_LOW selects inverted pin polarity (inactive = all ones).
module dynamic_display_scanner
  import dynamic_display_scanner_pkg::*;
#(
  parameter CountPath DWELL_CYCLES = DEF_COUNT,
  parameter CountPath BLANK_CYCLES = DD_BLANK_COUNT,
  parameter logic     ACTIVE_LOW   = 1'b1
) (
  input logic clk,
  input logic rst,
  dynamic_display_scanner_if.slave bus
);

  localparam DD_OutPath  SEG_POL  = ACTIVE_LOW ? '1 : '0;
  localparam DD_GatePath GATE_POL = ACTIVE_LOW ? '1 : '0;

  generate
    if (BLANK_CYCLES == '0) begin : g_blank_too_small
      $error("BLANK_CYCLES must be at least 1");
    end
    if (BLANK_CYCLES >= DWELL_CYCLES) begin : g_blank_too_large
      $error("BLANK_CYCLES must be less than DWELL_CYCLES");
    end
  endgenerate

  DigitIdx    idx;
  logic       slotShow;
  logic       captureEn;
  DD_InPath   frame;
  DD_OutPath  seg_next;
  DD_GatePath gate_next;

  dd_slot_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .enable   (bus.enable),
    .idx      (idx),
    .slotShow (slotShow),
    .captureEn(captureEn)
  );

  // enable gates the decode so the pins blank on the very next edge, even
  // though the timer state only returns to slot start on that same edge.
  always_comb begin
    seg_next  = '0;
    gate_next = '0;
    if (bus.enable && slotShow) begin
      seg_next  = digit_byte(frame, idx);
      gate_next = digit_gate(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame          <= '0;
      bus.frameStart <= 1'b0;
      bus.segOut     <= SEG_POL;
      bus.gateOut    <= GATE_POL;
    end else begin
      bus.frameStart <= captureEn;
      if (captureEn) begin
        frame <= bus.ddIn;
      end
      bus.segOut  <= seg_next ^ SEG_POL;
      bus.gateOut <= gate_next ^ GATE_POL;
    end
  end

endmodule

// File: doc/dynamic_display_scanner.md
# dynamic_display_scanner

Time-multiplexing driver for the 4-digit 7-segment display. It takes a 32-bit word holding four raw segment bytes from the IO/LED control path and scans one digit at a time. For each digit it drives that digit's segment byte and a one-hot digit gate, with a blanking gap before each digit to prevent ghosting. It sits between the IO register block (upstream, producing `DD_InPath`) and the board pins.

## Interface
- `DWELL_CYCLES`, `DEF_COUNT` (28'h3000): clock cycles per digit slot, including blanking; width `COUNT_WIDTH`.
- `BLANK_CYCLES`, 28'd16: cycles at the start of each slot with all gates off; must satisfy 1 ≤ `BLANK_CYCLES` < `DWELL_CYCLES`.
- `ACTIVE_LOW`, 1'b1: when 1, `segOut` and `gateOut` are active-low (inactive = all ones).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  scan enable; low blanks the display and holds the scan at its start.
- `ddIn`  in  `DD_IN_WIDTH` (32)  segment bytes: digit0 = [`LED_0_POS`+:8] (31:24), digit1 = 23:16, digit2 = 15:8, digit3 = 7:0.
- `segOut`  out  `DD_OUT_WIDTH` (8)  segment drive for the currently gated digit.
- `gateOut`  out  `DD_GATE_WIDTH` (4)  one-hot digit gate; bit i selects digit i.
- `frameStart`  out  1  one-cycle pulse marking the cycle `ddIn` was captured.

## Operation
- Internal state:
  - `cnt` (`CountPath`): 0..`DWELL_CYCLES`-1.
  - `idx` (2 bit): current digit.
  - `frame` (32 bit): latched copy of `ddIn`.
- Two phases per slot:
  - BLANK: `cnt` < `BLANK_CYCLES`.
  - SHOW: `cnt` ≥ `BLANK_CYCLES`.
- Slot end: at `cnt` == `DWELL_CYCLES`-1, `cnt` returns to 0 and `idx` increments. `idx` wraps 3→0.
- Frame capture: `frame` ← `ddIn` only on cycles where `enable`, `idx`==0 and `cnt`==0. Changes to `ddIn` mid-frame are invisible until the next frame, so frames never tear.
- Output decode, registered (polarity applied after decode):
  - BLANK: gates off, segments off.
  - SHOW: `gateOut` = one-hot(`idx`), `segOut` = `frame` byte for `idx`.
- `frameStart` is registered: high one cycle after the capture cycle.
- `enable` low:
  - `cnt` and `idx` are forced to 0 and `frame` is held.
  - Outputs go inactive on the next edge.
  - When `enable` rises, the first enabled cycle is a capture cycle.
- Reset values: `cnt`=0, `idx`=0, `frame`=0, `frameStart`=0, `segOut`/`gateOut` inactive (8'hFF/4'hF when `ACTIVE_LOW`). Reset mid-scan aborts the slot immediately (asynchronous); the scan restarts at digit 0 as above.
- Counter arithmetic is unsigned `COUNT_WIDTH`; `cnt` never exceeds `DWELL_CYCLES`-1, so there is no overflow.

## Timing
- Output latency: 1 cycle from internal state to pins.
- Internal-state pattern for `idx`=i: BLANK at cycles 0..B-1, SHOW at cycles B..D-1 (B = `BLANK_CYCLES`, D = `DWELL_CYCLES`). Pins show the same pattern one cycle later.
- Frame period: 4·D cycles; `frameStart` period is 4·D.
- Gate and segment change on the same edge; no output glitches (all outputs flopped).
- Never more than one gate bit active; all gates are inactive for exactly B cycles between digits.
- `ddIn` sampled on the capture edge with standard setup/hold; no handshake.

## Structure
- Shared package, already present: `DD_InPath`, `DD_OutPath`, `DD_GatePath`, `CountPath`, `COUNT_WIDTH`, `DEF_COUNT`, `LED_n_POS`.
- Add to the package: `DD_BLANK_COUNT` (default blanking) and `DD_DIGIT_NUM` = 4.
- Sub-module `dd_slot_timer`: owns `cnt`/`idx`/phase and emits `slotShow` plus `captureEn`. The top level holds `frame`, the decode and the output flops.
- Elaboration assertions: `BLANK_CYCLES` ≥ 1 and `BLANK_CYCLES` < `DWELL_CYCLES`.

## Test plan
All cases use `DWELL_CYCLES`=8, `BLANK_CYCLES`=2 and `ACTIVE_LOW`=1 unless stated.
- Reset then `enable`=1, `ddIn`=32'h11223344 → `frameStart` pulses at cycle 1; digit0 pins cycles 3..8 show `segOut`=8'hEE, `gateOut`=4'hE.
- Continue scanning → digit1 `segOut`=8'hDD/`gateOut`=4'hD, digit2 8'hCC/4'hB, digit3 8'hBB/4'h7, each preceded by exactly 2 blank cycles (8'hFF/4'hF); `frameStart` period = 32.
- Change `ddIn` to 32'hAABBCCDD while digit1 is shown → remainder of the frame still shows 22/33/44 values; the next frame shows AA (pins 8'h55) on digit0.
- Drop `enable` mid-slot of digit2 → outputs inactive next cycle. Re-raise it → capture cycle with a `frameStart` pulse, then scanning resumes at digit0.
- Assert `rst` mid-SHOW, asynchronously between edges → `segOut`=8'hFF, `gateOut`=4'hF, `frameStart`=0 immediately; release → same sequence as the first test.
- `ACTIVE_LOW`=0, `ddIn`=32'h80400201 → digit0 shows `segOut`=8'h80 with `gateOut`=4'h1; blank cycles drive 8'h00/4'h0. Throughout, the bench checks that no more than one gate is ever active.
